// File: rtl/pic_pkg.sv
// Shared types and defaults for the UDP picture-RAM write sequencer.
package pic_pkg;

  localparam int unsigned PIC_W_DEF     = 80;
  localparam int unsigned PIC_H_DEF     = 80;
  localparam int unsigned PIC_BYTES_DEF = PIC_W_DEF * PIC_H_DEF * 2;
  localparam logic [7:0]  MAGIC_DEF     = 8'h5A;
  localparam int unsigned SOF_BIT       = 0;

  typedef enum logic [2:0] {
    ST_HDR0,
    ST_HDR1,
    ST_DATA,
    ST_COMMIT,
    ST_WAIT_BANK,
    ST_DISCARD
  } state_e;

endpackage

// File: rtl/pic_wr_stat.sv
// Committed-picture counter (wrapping) and error counter (saturating).
module pic_wr_stat (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        commit_i,
  input  logic        err_i,
  output logic [15:0] frame_cnt_o,
  output logic [7:0]  err_cnt_o
);

  logic [15:0] frame_cnt_q;
  logic [7:0]  err_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (commit_i) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (err_i && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign frame_cnt_o = frame_cnt_q;
  assign err_cnt_o   = err_cnt_q;

endmodule

// File: rtl/pic_wr_ctrl.sv
// Parses UDP payload into double-buffered RGB565 pictures and drives RAM port A.
// Optional live statistics counters under `PIC_WR_STAT_EN.
module pic_wr_ctrl
  import pic_pkg::*;
#(
  parameter int unsigned PIC_W  = PIC_W_DEF,
  parameter int unsigned PIC_H  = PIC_H_DEF,
  parameter int unsigned ADDR_W = 16,
  parameter logic [7:0]  MAGIC  = MAGIC_DEF
) (
  input  logic              rgmii_clk,
  input  logic              rst,
  input  logic [7:0]        udp_rx_data,
  input  logic              udp_rx_en,
  input  logic              udp_rx_done,
  input  logic              disp_take,
  output logic              ram_wea,
  output logic [ADDR_W-1:0] ram_addra,
  output logic [7:0]        ram_dia,
  output logic              rd_bank,
  output logic              frame_ready,
  output logic [15:0]       frame_cnt,
  output logic [7:0]        err_cnt
);

  localparam int unsigned PIC_BYTES = PIC_W * PIC_H * 2;
  localparam int unsigned OFF_W     = $clog2(PIC_BYTES);

  state_e              state_q, state_d;
  logic                wr_bank_q, wr_bank_d;
  logic                rd_bank_q, rd_bank_d;
  logic                frame_ready_q, frame_ready_d;
  logic                frame_open_q, frame_open_d;
  logic                pkt_act_q, pkt_act_d;
  logic [OFF_W-1:0]    offset_q, offset_d;
  logic                ram_wea_q, ram_wea_d;
  logic [ADDR_W-1:0]   ram_addra_q, ram_addra_d;
  logic [7:0]          ram_dia_q, ram_dia_d;
  logic                commit_c;
  logic                err_c;

  always_ff @(posedge rgmii_clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_HDR0;
      wr_bank_q     <= 1'b1;
      rd_bank_q     <= 1'b0;
      frame_ready_q <= 1'b0;
      frame_open_q  <= 1'b0;
      pkt_act_q     <= 1'b0;
      offset_q      <= '0;
      ram_wea_q     <= 1'b0;
      ram_addra_q   <= '0;
      ram_dia_q     <= '0;
    end else begin
      state_q       <= state_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      frame_ready_q <= frame_ready_d;
      frame_open_q  <= frame_open_d;
      pkt_act_q     <= pkt_act_d;
      offset_q      <= offset_d;
      ram_wea_q     <= ram_wea_d;
      ram_addra_q   <= ram_addra_d;
      ram_dia_q     <= ram_dia_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wr_bank_d     = wr_bank_q;
    rd_bank_d     = rd_bank_q;
    frame_ready_d = frame_ready_q;
    frame_open_d  = frame_open_q;
    offset_d      = offset_q;
    ram_wea_d     = 1'b0;
    ram_addra_d   = ram_addra_q;
    ram_dia_d     = ram_dia_q;
    commit_c      = 1'b0;
    err_c         = 1'b0;
    // Tracks whether a packet is in flight, so WAIT_BANK knows where to resume.
    pkt_act_d     = udp_rx_done ? 1'b0 : (udp_rx_en ? 1'b1 : pkt_act_q);

    case (state_q)
      ST_HDR0: begin
        if (udp_rx_en) begin
          if (udp_rx_data == MAGIC) begin
            state_d = ST_HDR1;
          end else begin
            state_d = ST_DISCARD;
            err_c   = 1'b1;
          end
        end
      end
      ST_HDR1: begin
        if (udp_rx_en) begin
          if (udp_rx_data[SOF_BIT]) begin
            offset_d     = '0;
            frame_open_d = 1'b1;
            state_d      = ST_DATA;
            err_c        = frame_open_q;
          end else if (frame_open_q) begin
            state_d = ST_DATA;
          end else begin
            state_d = ST_DISCARD;
            err_c   = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (udp_rx_en) begin
          ram_wea_d   = 1'b1;
          ram_addra_d = wr_bank_q ? (ADDR_W'(PIC_BYTES) + ADDR_W'(offset_q))
                                  : ADDR_W'(offset_q);
          ram_dia_d   = udp_rx_data;
          offset_d    = offset_q + 1'b1;
          if (offset_q == OFF_W'(PIC_BYTES - 1)) state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        rd_bank_d     = wr_bank_q;
        frame_ready_d = 1'b1;
        wr_bank_d     = ~wr_bank_q;
        frame_open_d  = 1'b0;
        commit_c      = 1'b1;
        state_d       = ST_WAIT_BANK;
      end
      ST_WAIT_BANK: begin
        if (disp_take && frame_ready_q) begin
          frame_ready_d = 1'b0;
          state_d = (udp_rx_done || (!pkt_act_q && !udp_rx_en)) ? ST_HDR0 : ST_DISCARD;
        end
      end
      ST_DISCARD: ;
      default: state_d = ST_HDR0;
    endcase

    // Packet end is applied after the byte of the same cycle has been handled.
    if (udp_rx_done && (state_d != ST_COMMIT) &&
        (state_q inside {ST_HDR0, ST_HDR1, ST_DATA, ST_DISCARD})) begin
      state_d = frame_ready_q ? ST_WAIT_BANK : ST_HDR0;
    end
  end

  assign ram_wea     = ram_wea_q;
  assign ram_addra   = ram_addra_q;
  assign ram_dia     = ram_dia_q;
  assign rd_bank     = rd_bank_q;
  assign frame_ready = frame_ready_q;

`ifdef PIC_WR_STAT_EN
  pic_wr_stat u_stat (
    .clk_i       (rgmii_clk),
    .rst_i       (rst),
    .commit_i    (commit_c),
    .err_i       (err_c),
    .frame_cnt_o (frame_cnt),
    .err_cnt_o   (err_cnt)
  );
`else
  logic unused_stat;
  assign unused_stat = commit_c ^ err_c;
  assign frame_cnt   = '0;
  assign err_cnt     = '0;
`endif

endmodule
